// File: rtl/result_uart_tx.sv
// Transmit side of the ALU-over-UART link: a one-entry hold register feeding
// an 8N1 serialiser paced by the shared oversampling baud tick.
module result_uart_tx #(
  parameter int unsigned NB_DATA    = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned SB_TICK    = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_tx_done,
  output logic               o_overrun
);

  // The tick counter has to reach the longer of the data-bit and stop-bit lengths.
  localparam int unsigned TickMax = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int unsigned TickW   = (TickMax > 1) ? $clog2(TickMax) : 1;
  localparam int unsigned BitW    = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [TickW-1:0] DataTickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [TickW-1:0] StopTickLast = TickW'(SB_TICK - 1);
  localparam logic [BitW-1:0]  BitLast      = BitW'(NB_DATA - 1);

  typedef enum logic [3:0] {
    StIdle  = 4'b0001,
    StStart = 4'b0010,
    StData  = 4'b0100,
    StStop  = 4'b1000
  } state_e;

  state_e             state_q;
  logic [TickW-1:0]   tick_cnt_q;
  logic [BitW-1:0]    bit_cnt_q;
  logic [NB_DATA-1:0] shift_q;
  logic               tx_q;
  logic               done_q;

  logic               hold_full_q;
  logic [NB_DATA-1:0] hold_data_q;
  logic               overrun_q;

  logic               drain;
  logic               accept;

  // Hold register handshake: a byte may enter while the hold entry is empty or
  // is being moved into the shift register in this very cycle.
  always_comb begin
    drain  = (state_q == StIdle) && hold_full_q;
    accept = i_valid && (!hold_full_q || drain);
  end

  // One-entry hold register and the overrun strobe for dropped results.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      overrun_q <= i_valid && !accept;
      if (accept) begin
        hold_full_q <= 1'b1;
        hold_data_q <= i_data;
      end else if (drain) begin
        hold_full_q <= 1'b0;
      end
    end
  end

  // Frame FSM; line level and done strobe are registered alongside the state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (drain) begin
            shift_q    <= hold_data_q;
            tick_cnt_q <= '0;
            tx_q       <= 1'b0;
            state_q    <= StStart;
          end
        end
        StStart: begin
          if (i_tick) begin
            if (tick_cnt_q == DataTickLast) begin
              tick_cnt_q <= '0;
              bit_cnt_q  <= '0;
              tx_q       <= shift_q[0];
              state_q    <= StData;
            end else begin
              tick_cnt_q <= tick_cnt_q + TickW'(1);
            end
          end
        end
        StData: begin
          if (i_tick) begin
            if (tick_cnt_q == DataTickLast) begin
              tick_cnt_q <= '0;
              if (bit_cnt_q == BitLast) begin
                tx_q    <= 1'b1;
                state_q <= StStop;
              end else begin
                // Next line level is the bit that moves into position 0.
                shift_q   <= shift_q >> 1;
                bit_cnt_q <= bit_cnt_q + BitW'(1);
                tx_q      <= shift_q[1];
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + TickW'(1);
            end
          end
        end
        StStop: begin
          if (i_tick) begin
            if (tick_cnt_q == StopTickLast) begin
              tick_cnt_q <= '0;
              done_q     <= 1'b1;
              tx_q       <= 1'b1;
              state_q    <= StIdle;
            end else begin
              tick_cnt_q <= tick_cnt_q + TickW'(1);
            end
          end
        end
        default: begin
          // Corrupted state encoding: fall back to an idle, high line.
          state_q    <= StIdle;
          tick_cnt_q <= '0;
          bit_cnt_q  <= '0;
          tx_q       <= 1'b1;
        end
      endcase
    end
  end

  assign o_tx      = tx_q;
  assign o_busy    = (state_q != StIdle) || hold_full_q;
  assign o_tx_done = done_q;
  assign o_overrun = overrun_q;

endmodule
